// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, port IDs and defaults.
package mem_arbiter_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef logic port_t;
  localparam port_t PORT_F = 1'b0;
  localparam port_t PORT_L = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational pick, last_grant pointer advanced only on a taken grant.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid_c,
  output logic       gnt_port_c
);

  port_t last_grant;

  always_comb begin
    gnt_valid_c = |req;
    gnt_port_c  = PORT_F;
    if (req[PORT_F] && req[PORT_L]) gnt_port_c = ~last_grant;
    else if (req[PORT_L])           gnt_port_c = PORT_L;
  end

  // Reset to L so the first tie after reset goes to fetch.
  always_ff @(posedge clk) begin
    if (rst)                      last_grant <= PORT_L;
    else if (en && gnt_valid_c)   last_grant <= gnt_port_c;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (F) and LSU (L): grant, hold mem_req until
// mem_ready or timeout, then a one-cycle response pulse to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BYTE_DATA_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       f_req,
  input  logic [DATA_WIDTH-1:0]      f_addr,
  output logic                       f_valid,
  output logic [DATA_WIDTH-1:0]      f_rdata,
  input  logic                       l_req,
  input  logic                       l_we,
  input  logic [DATA_WIDTH-1:0]      l_addr,
  input  logic [DATA_WIDTH-1:0]      l_wdata,
  input  logic [BYTE_DATA_WIDTH-1:0] l_byte_enable,
  output logic                       l_valid,
  output logic [DATA_WIDTH-1:0]      l_rdata,
  output logic                       err,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [DATA_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable,
  input  logic                       mem_ready,
  input  logic [DATA_WIDTH-1:0]      mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  state_t state, next_state;
  port_t  owner, owner_d;
  logic   [CNT_W-1:0] cnt, cnt_d;
  logic   gnt_valid_c, gnt_port_c, timeout_c;
  logic   [DATA_WIDTH-1:0] cap_c;

  logic                       f_valid_d, l_valid_d, err_d, mem_req_d, mem_we_d;
  logic [DATA_WIDTH-1:0]      f_rdata_d, l_rdata_d, mem_addr_d, mem_wdata_d;
  logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable_d;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .req         ({l_req, f_req}),
    .en          (state == ST_IDLE),
    .gnt_valid_c (gnt_valid_c),
    .gnt_port_c  (gnt_port_c)
  );

  assign timeout_c = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (gnt_valid_c) next_state = ST_BUSY;
      ST_BUSY: if (mem_ready || timeout_c) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Next values of every registered output; mem_ready wins over a same-cycle timeout.
  always_comb begin
    mem_req_d         = (next_state == ST_BUSY);
    f_valid_d         = (next_state == ST_RESP) && (owner == PORT_F);
    l_valid_d         = (next_state == ST_RESP) && (owner == PORT_L);
    err_d             = err;
    f_rdata_d         = f_rdata;
    l_rdata_d         = l_rdata;
    mem_we_d          = mem_we;
    mem_addr_d        = mem_addr;
    mem_wdata_d       = mem_wdata;
    mem_byte_enable_d = mem_byte_enable;
    owner_d           = owner;
    cnt_d             = cnt;
    cap_c             = '0;
    case (state)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          owner_d = gnt_port_c;
          cnt_d   = '0;
          if (gnt_port_c == PORT_F) begin
            mem_we_d          = 1'b0;
            mem_addr_d        = f_addr;
            mem_wdata_d       = '0;
            mem_byte_enable_d = '1;
          end else begin
            mem_we_d          = l_we;
            mem_addr_d        = l_addr;
            mem_wdata_d       = l_wdata;
            mem_byte_enable_d = l_byte_enable;
          end
        end
      end
      ST_BUSY: begin
        if (cnt != CNT_MAX) cnt_d = cnt + CNT_W'(1);
        if (next_state == ST_RESP) begin
          err_d = ~mem_ready;
          cap_c = (mem_ready && !mem_we) ? mem_rdata : '0;
          if (owner == PORT_F) f_rdata_d = cap_c;
          else                 l_rdata_d = cap_c;
        end
      end
      ST_RESP: begin
        err_d     = 1'b0;
        f_rdata_d = '0;
        l_rdata_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_valid         <= 1'b0;
      l_valid         <= 1'b0;
      err             <= 1'b0;
      f_rdata         <= '0;
      l_rdata         <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      owner           <= PORT_F;
      cnt             <= '0;
    end else begin
      f_valid         <= f_valid_d;
      l_valid         <= l_valid_d;
      err             <= err_d;
      f_rdata         <= f_rdata_d;
      l_rdata         <= l_rdata_d;
      mem_req         <= mem_req_d;
      mem_we          <= mem_we_d;
      mem_addr        <= mem_addr_d;
      mem_wdata       <= mem_wdata_d;
      mem_byte_enable <= mem_byte_enable_d;
      owner           <= owner_d;
      cnt             <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// transaction-level model of round-robin arbitration, latency and timeout.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, f_req, f_valid, l_req, l_we, l_valid, err;
  logic          mem_req, mem_we, mem_ready;
  logic [DW-1:0] f_addr, f_rdata, l_addr, l_wdata, l_rdata;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [BW-1:0] l_byte_enable, mem_byte_enable;

  mem_arbiter #(.DATA_WIDTH(DW), .BYTE_DATA_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_byte_enable(l_byte_enable), .l_valid(l_valid), .l_rdata(l_rdata),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 0; f_addr = '0; l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    l_byte_enable = '0; mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [4*DW+BW+5:0] all_out;
    idle_inputs();
    rst = 1; tick(); tick();
    all_out = {f_valid, l_valid, err, mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable, f_rdata, l_rdata};
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs: got %0h expected 0", all_out); end
    rst = 0; tick();
    all_out = {f_valid, l_valid, err, mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable, f_rdata, l_rdata};
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_idle_outputs: got %0h expected 0", all_out); end
  endtask

  task automatic test_single_fetch();
    f_req = 1; f_addr = 32'h100;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable} !== {1'b1, 1'b0, 32'h100, 32'h0, 4'hF}) begin
      failures++;
      $display("FAIL fetch_mem_bus: got req=%0b we=%0b addr=%0h wd=%0h be=%0h expected 1 0 100 0 f",
               mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable);
    end
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    checks++;
    if ({f_valid, l_valid, err, mem_req, f_rdata} !== {4'b1000, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL fetch_resp: got fv=%0b lv=%0b err=%0b mreq=%0b rdata=%0h expected 1 0 0 0 deadbeef",
               f_valid, l_valid, err, mem_req, f_rdata);
    end
    f_req = 0; mem_ready = 0;
    tick();
    checks++;
    if ({f_valid, f_rdata} !== '0) begin
      failures++; $display("FAIL fetch_resp_clear: got fv=%0b rdata=%0h expected 0 0", f_valid, f_rdata);
    end
  endtask

  task automatic test_lsu_store();
    int pulses = 0;
    l_req = 1; l_we = 1; l_addr = 32'h2004; l_wdata = 32'hAB; l_byte_enable = 4'b0001;
    tick();
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable} !== {1'b1, 1'b1, 32'h2004, 32'hAB, 4'b0001}) begin
        failures++;
        $display("FAIL store_bus_cycle%0d: got req=%0b we=%0b addr=%0h wd=%0h be=%0h expected 1 1 2004 ab 1",
                 c, mem_req, mem_we, mem_addr, mem_wdata, mem_byte_enable);
      end
      if (l_valid) pulses++;
      if (c == 3) begin mem_ready = 1; mem_rdata = 32'h5555AAAA; end
      tick();
    end
    mem_ready = 0; l_req = 0;
    checks++;
    if ({l_valid, err, l_rdata} !== {2'b10, 32'h0}) begin
      failures++;
      $display("FAIL store_resp: got lv=%0b err=%0b rdata=%0h expected 1 0 0", l_valid, err, l_rdata);
    end
    if (l_valid) pulses++;
    tick();
    if (l_valid) pulses++;
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL store_pulse_count: got %0d expected 1", pulses); end
  endtask

  task automatic test_contention();
    logic exp_l;
    idle_inputs();
    rst = 1; tick();
    rst = 0; f_req = 1; f_addr = 32'h1000; l_req = 1; l_addr = 32'h2000;
    for (int t = 0; t < 4; t++) begin
      exp_l = (t % 2) == 1;
      tick();
      checks++;
      if (mem_addr !== (exp_l ? 32'h2000 : 32'h1000)) begin
        failures++; $display("FAIL contention_grant%0d: got addr=%0h expected %0h", t, mem_addr, exp_l ? 32'h2000 : 32'h1000);
      end
      mem_ready = 1; mem_rdata = 32'(t);
      tick();
      mem_ready = 0;
      checks++;
      if ({f_valid, l_valid} !== {~exp_l, exp_l}) begin
        failures++; $display("FAIL contention_valid%0d: got fv=%0b lv=%0b expected %0b %0b", t, f_valid, l_valid, ~exp_l, exp_l);
      end
      tick();
      checks++;
      if ({f_valid, l_valid} !== 2'b00) begin
        failures++; $display("FAIL contention_pulse_len%0d: got fv=%0b lv=%0b expected 0 0", t, f_valid, l_valid);
      end
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    l_req = 1; l_we = 0; l_addr = 32'h3000; mem_rdata = 32'h12345678;
    tick();
    while (mem_req === 1'b1 && n < 10) begin n++; tick(); end
    checks++;
    if (n != TO) begin failures++; $display("FAIL timeout_busy_len: got %0d expected %0d", n, TO); end
    checks++;
    if ({l_valid, err, l_rdata} !== {2'b11, 32'h0}) begin
      failures++; $display("FAIL timeout_resp: got lv=%0b err=%0b rdata=%0h expected 1 1 0", l_valid, err, l_rdata);
    end
    l_req = 0;
    tick();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear: got %0b expected 0", err); end
    l_req = 1; l_addr = 32'h3004;
    tick();
    mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ready = 0; l_req = 0;
    checks++;
    if ({l_valid, err, l_rdata} !== {2'b10, 32'hCAFEF00D}) begin
      failures++; $display("FAIL timeout_recover: got lv=%0b err=%0b rdata=%0h expected 1 0 cafef00d", l_valid, err, l_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    f_req = 1; f_addr = 32'h500;
    tick(); tick();
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_busy_precond: got mem_req=%0b expected 1", mem_req); end
    rst = 1;
    tick();
    rst = 0; f_addr = 32'h3000; l_req = 1; l_addr = 32'h4000;
    checks++;
    if ({mem_req, f_valid, l_valid} !== 3'b000) begin
      failures++; $display("FAIL rst_busy_abort: got mreq=%0b fv=%0b lv=%0b expected 0 0 0", mem_req, f_valid, l_valid);
    end
    tick();
    checks++;
    if ({mem_req, mem_addr, f_valid, l_valid} !== {1'b1, 32'h3000, 2'b00}) begin
      failures++; $display("FAIL rst_busy_tie_to_f: got mreq=%0b addr=%0h fv=%0b lv=%0b expected 1 3000 0 0",
                           mem_req, mem_addr, f_valid, l_valid);
    end
    mem_ready = 1;
    tick();
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_late_ready();
    mem_ready = 1; mem_rdata = 32'h77;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({mem_req, f_valid, l_valid, err} !== 4'b0000) begin
        failures++; $display("FAIL late_ready_idle%0d: got mreq=%0b fv=%0b lv=%0b err=%0b expected 0", c, mem_req, f_valid, l_valid, err);
      end
    end
    mem_ready = 0; f_req = 1; f_addr = 32'h600;
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin
      failures++; $display("FAIL late_ready_grant: got mreq=%0b addr=%0h expected 1 600", mem_req, mem_addr);
    end
    mem_ready = 1;
    tick();
    f_req = 0;
    checks++;
    if (f_valid !== 1'b1) begin failures++; $display("FAIL late_ready_resp: got fv=%0b expected 1", f_valid); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({mem_req, f_valid, l_valid} !== 3'b000) begin
        failures++; $display("FAIL late_ready_after%0d: got mreq=%0b fv=%0b lv=%0b expected 0", c, mem_req, f_valid, l_valid);
      end
    end
    idle_inputs();
    tick();
  endtask

  // Transaction-level model: round-robin pick among pending ports, busy length min(ready_delay, TO).
  task automatic test_random();
    logic          last_l = 1'b1;
    logic          g;
    logic [DW-1:0] e_addr, e_wd, rd, e_rd;
    logic          e_we, e_err;
    logic [BW-1:0] e_be;
    int            d, busy, e_busy;
    idle_inputs();
    rst = 1; tick(); rst = 0;
    for (int t = 0; t < 40; t++) begin
      if (!f_req && $urandom_range(0, 1) == 1) begin f_req = 1; f_addr = $urandom; end
      if (!l_req && $urandom_range(0, 1) == 1) begin
        l_req = 1; l_we = 1'($urandom); l_addr = $urandom; l_wdata = $urandom; l_byte_enable = 4'($urandom);
      end
      if (!f_req && !l_req) begin f_req = 1; f_addr = $urandom; end
      g = (f_req && l_req) ? ~last_l : l_req;
      last_l = g;
      e_addr = g ? l_addr : f_addr;
      e_we   = g ? l_we : 1'b0;
      e_wd   = g ? l_wdata : '0;
      e_be   = g ? l_byte_enable : '1;
      d = $urandom_range(1, TO + 1);
      e_busy = (d > TO) ? TO : d;
      e_err  = (d > TO);
      rd = '0;
      tick();
      busy = 0;
      while (mem_req === 1'b1 && busy < 10) begin
        busy++;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_byte_enable} !== {e_we, e_addr, e_wd, e_be}) begin
          failures++;
          $display("FAIL rand%0d_bus: got we=%0b addr=%0h wd=%0h be=%0h expected %0b %0h %0h %0h",
                   t, mem_we, mem_addr, mem_wdata, mem_byte_enable, e_we, e_addr, e_wd, e_be);
        end
        mem_ready = (busy == d);
        mem_rdata = $urandom;
        if (busy == d) rd = mem_rdata;
        tick();
      end
      mem_ready = 0;
      e_rd = (e_err || e_we) ? '0 : rd;
      checks++;
      if (busy != e_busy) begin failures++; $display("FAIL rand%0d_busy_len: got %0d expected %0d", t, busy, e_busy); end
      checks++;
      if ({f_valid, l_valid, err, (g ? l_rdata : f_rdata)} !== {~g, g, e_err, e_rd}) begin
        failures++;
        $display("FAIL rand%0d_resp: got fv=%0b lv=%0b err=%0b rdata=%0h expected %0b %0b %0b %0h",
                 t, f_valid, l_valid, err, (g ? l_rdata : f_rdata), ~g, g, e_err, e_rd);
      end
      if (g) l_req = 0; else f_req = 0;
      tick();
      checks++;
      if ({f_valid, l_valid, err} !== 3'b000) begin
        failures++; $display("FAIL rand%0d_idle: got fv=%0b lv=%0b err=%0b expected 0 0 0", t, f_valid, l_valid, err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_lsu_store();
    test_contention();
    test_timeout();
    test_reset_mid_busy();
    test_late_ready();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
